// File: rtl/fir_pkg.sv
// Shared state encoding and default geometry for the decimating FIR MAC scheduler.
package fir_pkg;

  typedef enum logic [1:0] {
    SM_IDLE = 2'd0,
    SM_MAC  = 2'd1,
    SM_DMP  = 2'd2
  } sm_t;

  localparam int unsigned DEF_NCH  = 2;
  localparam int unsigned DEF_PSZ  = 8;
  localparam int unsigned DEF_DLOG = 3;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fir_dec_sched_rr_arb.sv
// Round-robin arbiter: the search starts at the channel after the last grant.
module rr_arb #(
  parameter int unsigned n  = 2,
  parameter int unsigned iw = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [n-1:0]  req,
  input  logic          adv,
  output logic [n-1:0]  gnt,
  output logic [iw-1:0] gnt_idx,
  output logic          any
);

  logic [iw-1:0] ptr_q, ptr_d;

  // Two passes: first the channels at or above the pointer, then the wrap-around.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    for (int unsigned i = 0; i < n; i++) begin
      if (!any && req[i] && (iw'(i) >= ptr_q)) begin
        any     = 1'b1;
        gnt[i]  = 1'b1;
        gnt_idx = iw'(i);
      end
    end
    for (int unsigned i = 0; i < n; i++) begin
      if (!any && req[i]) begin
        any     = 1'b1;
        gnt[i]  = 1'b1;
        gnt_idx = iw'(i);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (adv && any) begin
      ptr_d = (gnt_idx == iw'(n - 1)) ? '0 : gnt_idx + iw'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/fir_dec_sched.sv
// Decimating FIR scheduler: tracks per-channel sample buffers and time-shares one MAC engine.
module fir_dec_sched
  import fir_pkg::*;
#(
  parameter  int unsigned nch  = DEF_NCH,
  parameter  int unsigned psz  = DEF_PSZ,
  parameter  int unsigned dlog = DEF_DLOG,
  localparam int unsigned chw  = idx_w(nch)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [nch-1:0]     ena,
  input  logic [psz-1:0]     taps,
  input  logic               ovr_clr,
  output logic [nch*psz-1:0] w_addr,
  output logic [chw-1:0]     r_ch,
  output logic [psz-1:0]     r_addr,
  output logic [psz-1:0]     c_addr,
  output logic               mac_ena,
  output logic               dump,
  output logic [chw-1:0]     dump_ch,
  output logic               busy,
  output logic [nch-1:0]     overrun
);

  sm_t            state_q, state_d;
  logic [chw-1:0] r_ch_q, r_ch_d, dump_ch_q, dump_ch_d;
  logic [psz-1:0] r_addr_q, r_addr_d, c_addr_q, c_addr_d, tap_lim_q, tap_lim_d;
  logic           mac_ena_q, mac_ena_d, dump_q, dump_d;
  logic [psz-1:0] w_addr_q [nch];
  logic [psz-1:0] w_addr_d [nch];
  logic [psz-1:0] jaddr_q  [nch];
  logic [psz-1:0] jaddr_d  [nch];
  logic [nch-1:0] pending_q, pending_d, overrun_q, overrun_d, blk_end, clr;
  logic [nch-1:0] arb_gnt;
  logic [chw-1:0] arb_idx;
  logic           arb_any;

  rr_arb #(
    .n  (nch),
    .iw (chw)
  ) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (pending_q),
    .adv     (state_q == SM_IDLE),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .any     (arb_any)
  );

  assign clr = (state_q == SM_IDLE) ? arb_gnt : '0;

  // A new block set beats the grant clear; a set onto a still-pending job is an overrun.
  for (genvar k = 0; k < nch; k++) begin : g_ch
    assign blk_end[k]   = ena[k] && (w_addr_q[k][dlog-1:0] == '1);
    assign w_addr_d[k]  = ena[k] ? w_addr_q[k] + psz'(1) : w_addr_q[k];
    assign jaddr_d[k]   = blk_end[k] ? w_addr_q[k] : jaddr_q[k];
    assign pending_d[k] = blk_end[k] | (pending_q[k] & ~clr[k]);
    assign overrun_d[k] = (blk_end[k] & pending_q[k] & ~clr[k]) | (overrun_q[k] & ~ovr_clr);
    assign w_addr[k*psz +: psz] = w_addr_q[k];
  end

  always_comb begin
    state_d   = state_q;
    r_ch_d    = r_ch_q;
    r_addr_d  = r_addr_q;
    c_addr_d  = c_addr_q;
    tap_lim_d = tap_lim_q;
    mac_ena_d = mac_ena_q;
    dump_d    = dump_q;
    dump_ch_d = dump_ch_q;
    case (state_q)
      SM_IDLE: begin
        if (arb_any) begin
          r_ch_d    = arb_idx;
          r_addr_d  = jaddr_q[arb_idx];
          c_addr_d  = '0;
          tap_lim_d = taps;
          mac_ena_d = 1'b1;
          state_d   = SM_MAC;
        end
      end
      SM_MAC: begin
        if (c_addr_q != tap_lim_q) begin
          r_addr_d = r_addr_q - psz'(1);
          c_addr_d = c_addr_q + psz'(1);
        end else begin
          mac_ena_d = 1'b0;
          dump_d    = 1'b1;
          dump_ch_d = r_ch_q;
          state_d   = SM_DMP;
        end
      end
      SM_DMP: begin
        dump_d  = 1'b0;
        state_d = SM_IDLE;
      end
      default: begin
        mac_ena_d = 1'b0;
        dump_d    = 1'b0;
        state_d   = SM_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= SM_IDLE;
      r_ch_q    <= '0;
      r_addr_q  <= '0;
      c_addr_q  <= '0;
      tap_lim_q <= '0;
      mac_ena_q <= 1'b0;
      dump_q    <= 1'b0;
      dump_ch_q <= '0;
      w_addr_q  <= '{default: '0};
      jaddr_q   <= '{default: '0};
      pending_q <= '0;
      overrun_q <= '0;
    end else begin
      state_q   <= state_d;
      r_ch_q    <= r_ch_d;
      r_addr_q  <= r_addr_d;
      c_addr_q  <= c_addr_d;
      tap_lim_q <= tap_lim_d;
      mac_ena_q <= mac_ena_d;
      dump_q    <= dump_d;
      dump_ch_q <= dump_ch_d;
      w_addr_q  <= w_addr_d;
      jaddr_q   <= jaddr_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end

  assign r_ch    = r_ch_q;
  assign r_addr  = r_addr_q;
  assign c_addr  = c_addr_q;
  assign mac_ena = mac_ena_q;
  assign dump    = dump_q;
  assign dump_ch = dump_ch_q;
  assign busy    = (state_q == SM_MAC) || (state_q == SM_DMP);
  assign overrun = overrun_q;

endmodule

// File: tb/tb_fir_dec_sched.sv
// Directed bench for fir_dec_sched: job timing, arbitration, overrun, reset abort, pointer wrap.
module tb_fir_dec_sched;

  localparam int MAXJ = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  ena;
  logic [7:0]  taps;
  logic        ovr_clr;
  logic [15:0] w_addr;
  logic [0:0]  r_ch;
  logic [7:0]  r_addr;
  logic [7:0]  c_addr;
  logic        mac_ena;
  logic        dump;
  logic [0:0]  dump_ch;
  logic        busy;
  logic [1:0]  overrun;

  int total = 0;
  int bad   = 0;

  fir_dec_sched #(
    .nch  (2),
    .psz  (8),
    .dlog (3)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .ena     (ena),
    .taps    (taps),
    .ovr_clr (ovr_clr),
    .w_addr  (w_addr),
    .r_ch    (r_ch),
    .r_addr  (r_addr),
    .c_addr  (c_addr),
    .mac_ena (mac_ena),
    .dump    (dump),
    .dump_ch (dump_ch),
    .busy    (busy),
    .overrun (overrun)
  );

  always #5 clk = ~clk;

  // Job / dump log, sampled on the falling edge; cycle label = mcyc after that edge.
  int         mcyc     = 0;
  int         njob     = 0;
  int         ndump    = 0;
  logic       mac_prev = 1'b0;
  int         js  [MAXJ];
  int         jl  [MAXJ];
  logic [7:0] jr0 [MAXJ];
  logic [7:0] jrn [MAXJ];
  logic [7:0] jcn [MAXJ];
  logic [0:0] jch [MAXJ];
  int         dt  [MAXJ];
  logic [0:0] dc  [MAXJ];

  always @(negedge clk) begin
    mcyc <= mcyc + 1;
    if (reset) begin
      mac_prev <= 1'b0;
    end else begin
      mac_prev <= mac_ena;
      if (mac_ena && !mac_prev && njob < MAXJ) begin
        js[njob]  <= mcyc + 1;
        jl[njob]  <= 1;
        jr0[njob] <= r_addr;
        jrn[njob] <= r_addr;
        jcn[njob] <= c_addr;
        jch[njob] <= r_ch;
        njob      <= njob + 1;
      end else if (mac_ena && njob > 0) begin
        jl[njob-1]  <= jl[njob-1] + 1;
        jrn[njob-1] <= r_addr;
        jcn[njob-1] <= c_addr;
      end
      if (dump && ndump < MAXJ) begin
        dt[ndump] <= mcyc + 1;
        dc[ndump] <= dump_ch;
        ndump     <= ndump + 1;
      end
    end
  end

  function automatic int cur();
    return mcyc + 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse(input logic [1:0] e, input int n);
    for (int i = 0; i < n; i++) begin
      ena = e;
      tick();
    end
    ena = 2'b00;
  endtask

  int n;
  int a;
  int b_j;
  int b_d;

  initial begin
    reset   = 1'b1;
    ena     = 2'b00;
    taps    = 8'd0;
    ovr_clr = 1'b0;
    ticks(2);
    chk("rst_waddr",   32'(w_addr),  32'h0);
    chk("rst_raddr",   32'(r_addr),  32'h0);
    chk("rst_caddr",   32'(c_addr),  32'h0);
    chk("rst_mac",     32'(mac_ena), 32'h0);
    chk("rst_dump",    32'(dump),    32'h0);
    chk("rst_busy",    32'(busy),    32'h0);
    chk("rst_ovr",     32'(overrun), 32'h0);
    chk("rst_rch",     32'(r_ch),    32'h0);
    chk("rst_dumpch",  32'(dump_ch), 32'h0);
    reset = 1'b0;
    tick();

    // Long job on ch0: 246 taps, read pointer wraps below zero
    taps = 8'd245;
    b_j = njob; b_d = ndump;
    pulse(2'b01, 8);
    n = cur() - 1;
    chk("s1_waddr", 32'(w_addr), 32'h0008);
    chk("s1_busy_pend", 32'(busy), 32'h0);
    ticks(260);
    chk("s1_njob",   njob,  b_j + 1);
    chk("s1_start",  js[b_j], n + 2);
    chk("s1_len",    jl[b_j], 246);
    chk("s1_r0",     32'(jr0[b_j]), 32'h07);
    chk("s1_rn",     32'(jrn[b_j]), 32'h12);
    chk("s1_cn",     32'(jcn[b_j]), 32'd245);
    chk("s1_ch",     32'(jch[b_j]), 32'h0);
    chk("s1_ndump",  ndump, b_d + 1);
    chk("s1_dumpt",  dt[b_d], n + 248);
    chk("s1_dumpch", 32'(dc[b_d]), 32'h0);
    chk("s1_busy",   32'(busy), 32'h0);
    chk("s1_ovr",    32'(overrun), 32'h0);

    // Simultaneous blocks from a fresh reset: ch0 first, ch1 right after
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("s2_rst_waddr", 32'(w_addr), 32'h0);
    taps = 8'd3;
    b_j = njob; b_d = ndump;
    pulse(2'b11, 8);
    n = cur() - 1;
    ticks(20);
    chk("s2_njob",    njob, b_j + 2);
    chk("s2_a_ch",    32'(jch[b_j]), 32'h0);
    chk("s2_a_start", js[b_j], n + 2);
    chk("s2_a_len",   jl[b_j], 4);
    chk("s2_a_r0",    32'(jr0[b_j]), 32'h07);
    chk("s2_a_rn",    32'(jrn[b_j]), 32'h04);
    chk("s2_b_ch",    32'(jch[b_j+1]), 32'h1);
    chk("s2_b_start", js[b_j+1], n + 8);
    chk("s2_b_len",   jl[b_j+1], 4);
    chk("s2_b_r0",    32'(jr0[b_j+1]), 32'h07);
    chk("s2_ndump",   ndump, b_d + 2);
    chk("s2_d0",      dt[b_d], n + 6);
    chk("s2_d0ch",    32'(dc[b_d]), 32'h0);
    chk("s2_d1",      dt[b_d+1], n + 12);
    chk("s2_d1ch",    32'(dc[b_d+1]), 32'h1);
    chk("s2_ovr",     32'(overrun), 32'h0);
    chk("s2_waddr",   32'(w_addr), 32'h0808);

    // ch1 finishes two blocks during a 16-tap ch0 job; taps change mid-job
    taps = 8'd15;
    pulse(2'b01, 7);
    pulse(2'b10, 7);
    b_j = njob; b_d = ndump;
    ena = 2'b01;
    a = cur();
    tick();
    for (int i = 0; i < 9; i++) begin
      ena = 2'b10;
      if (i == 2) taps = 8'd3;
      tick();
    end
    ena = 2'b00;
    chk("s3_ovr_set", 32'(overrun), 32'h2);
    ticks(20);
    chk("s3_a_start", js[b_j], a + 2);
    chk("s3_a_len",   jl[b_j], 16);
    chk("s3_a_r0",    32'(jr0[b_j]), 32'h0F);
    chk("s3_a_rn",    32'(jrn[b_j]), 32'h00);
    chk("s3_b_ch",    32'(jch[b_j+1]), 32'h1);
    chk("s3_b_start", js[b_j+1], a + 20);
    chk("s3_b_len",   jl[b_j+1], 4);
    chk("s3_b_r0",    32'(jr0[b_j+1]), 32'h17);
    chk("s3_d0",      dt[b_d], a + 18);
    chk("s3_d1",      dt[b_d+1], a + 24);
    chk("s3_ndump",   ndump, b_d + 2);
    chk("s3_waddr",   32'(w_addr), 32'h1810);
    chk("s3_ovr_hold", 32'(overrun), 32'h2);
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    chk("s3_ovr_clr", 32'(overrun), 32'h0);

    // Reset at MAC cycle 100 aborts the job without a dump
    taps = 8'd245;
    b_d = ndump;
    pulse(2'b01, 8);
    ticks(100);
    chk("s4_mac_pre",   32'(mac_ena), 32'h1);
    chk("s4_caddr_pre", 32'(c_addr), 32'd99);
    chk("s4_raddr_pre", 32'(r_addr), 32'hB4);
    reset = 1'b1;
    #1;
    chk("s4_rst_mac",   32'(mac_ena), 32'h0);
    chk("s4_rst_busy",  32'(busy), 32'h0);
    chk("s4_rst_raddr", 32'(r_addr), 32'h0);
    chk("s4_rst_caddr", 32'(c_addr), 32'h0);
    chk("s4_rst_waddr", 32'(w_addr), 32'h0);
    chk("s4_rst_dump",  32'(dump), 32'h0);
    ticks(2);
    reset = 1'b0;
    ticks(5);
    chk("s4_nodump", ndump, b_d);
    taps = 8'd3;
    b_j = njob;
    pulse(2'b01, 8);
    n = cur() - 1;
    ticks(10);
    chk("s4_job_r0",  32'(jr0[b_j]), 32'h07);
    chk("s4_job_len", jl[b_j], 4);
    chk("s4_ndump",   ndump, b_d + 1);
    chk("s4_dumpt",   dt[b_d], n + 6);

    // Write pointer wraps; block ending at 0xFF reads from 0xFF
    pulse(2'b01, 240);
    pulse(2'b01, 8);
    n = cur() - 1;
    b_j = njob; b_d = ndump;
    chk("s5_wrap", 32'(w_addr), 32'h0000);
    ticks(10);
    chk("s5_start", js[b_j], n + 2);
    chk("s5_r0",    32'(jr0[b_j]), 32'hFF);
    chk("s5_rn",    32'(jrn[b_j]), 32'hFC);
    chk("s5_len",   jl[b_j], 4);
    chk("s5_ndump", ndump, b_d + 1);
    chk("s5_dumpt", dt[b_d], n + 6);
    chk("s5_ovr",   32'(overrun), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
